// File: rtl/asic_cmd_seq_pkg.sv
// Shared definitions for the ASIC command sequencer: default widths,
// the number of command beats per job, and the controller state type.
package asic_cmd_seq_pkg;

  localparam int DW_DEF    = 64;
  localparam int TW_DEF    = 4;
  localparam int NUM_BEATS = 5;
  localparam int BEAT_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/asic_cmd_seq_if.sv
// Handshake bundle between the host, the sequencer and the ASIC controller.
// The slave modport is the sequencer's view; master is the environment's view.
interface asic_cmd_seq_if import asic_cmd_seq_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF
) ();

  logic          job_valid_i;
  logic          job_ready_o;
  logic [DW-1:0] job_f0_i;
  logic [DW-1:0] job_f1_i;
  logic [DW-1:0] job_f2_i;
  logic [DW-1:0] job_f3_i;
  logic [DW-1:0] job_f4_i;
  logic [TW-1:0] job_tag_i;

  logic          cmd_valid_o;
  logic          cmd_ready_i;
  logic [DW-1:0] cmd_data_o;

  logic          resp_valid_i;
  logic          resp_ready_o;

  logic          done_valid_o;
  logic          done_ready_i;
  logic [TW-1:0] done_tag_o;
  logic [31:0]   done_cycles_o;
  logic          done_err_o;

  modport slave (
    input  job_valid_i, job_f0_i, job_f1_i, job_f2_i, job_f3_i, job_f4_i, job_tag_i,
    output job_ready_o,
    output cmd_valid_o, cmd_data_o,
    input  cmd_ready_i,
    input  resp_valid_i,
    output resp_ready_o,
    output done_valid_o, done_tag_o, done_cycles_o, done_err_o,
    input  done_ready_i
  );

  modport master (
    output job_valid_i, job_f0_i, job_f1_i, job_f2_i, job_f3_i, job_f4_i, job_tag_i,
    input  job_ready_o,
    input  cmd_valid_o, cmd_data_o,
    output cmd_ready_i,
    output resp_valid_i,
    input  resp_ready_o,
    input  done_valid_o, done_tag_o, done_cycles_o, done_err_o,
    output done_ready_i
  );

endinterface

// File: rtl/asic_job_fifo.sv
// Two-entry descriptor FIFO. No fall-through: a push into an empty FIFO
// becomes visible at the head on the following cycle. Full blocks pushes
// even when a pop happens in the same cycle.
module asic_job_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push_ok;
  logic         pop_ok;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign head    = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // payload storage; contents are don't-care while the slot is empty
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/asic_cmd_seq.sv
// Command sequencer: takes buffered job descriptors, issues their five
// fields as command beats, waits for the controller's completion (or a
// timeout) and hands a completion record with tag and cycle count to the host.
module asic_cmd_seq import asic_cmd_seq_pkg::*; #(
  parameter int DW      = DW_DEF,
  parameter int TW      = TW_DEF,
  parameter int TIMEOUT = 65535
) (
  input logic           clk,
  input logic           reset,
  asic_cmd_seq_if.slave bus
);

  localparam int               JOB_W     = NUM_BEATS * DW + TW;
  localparam int               REST_W    = (NUM_BEATS - 1) * DW;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
  localparam logic [31:0]      WAIT_LAST = 32'(TIMEOUT - 1);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  seq_state_t        state;
  logic [BEAT_W-1:0] beat_idx;
  logic [31:0]       run_cnt;
  logic [31:0]       wait_cnt;
  logic [REST_W-1:0] rest;
  logic [TW-1:0]     job_tag;

  logic              cmd_valid;
  logic [DW-1:0]     cmd_data;
  logic              resp_ready;
  logic              done_valid;
  logic [TW-1:0]     done_tag;
  logic [31:0]       done_cycles;
  logic              done_err;

  logic [JOB_W-1:0]  fifo_in;
  logic [JOB_W-1:0]  fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              beat_accept;

  assign fifo_in     = {bus.job_tag_i, bus.job_f4_i, bus.job_f3_i,
                        bus.job_f2_i, bus.job_f1_i, bus.job_f0_i};
  assign fifo_pop    = (state == ST_IDLE) && !fifo_empty;
  assign beat_accept = (state == ST_ISSUE) && bus.cmd_ready_i;

  asic_job_fifo #(.W(JOB_W)) u_job_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.job_valid_i),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.job_ready_o   = !fifo_full;
  assign bus.cmd_valid_o   = cmd_valid;
  assign bus.cmd_data_o    = cmd_data;
  assign bus.resp_ready_o  = resp_ready;
  assign bus.done_valid_o  = done_valid;
  assign bus.done_tag_o    = done_tag;
  assign bus.done_cycles_o = done_cycles;
  assign bus.done_err_o    = done_err;

  // latched job payload: fields 1..4 shift down one slot per accepted beat
  always_ff @(posedge clk) begin
    if (fifo_pop) begin
      rest    <= fifo_head[NUM_BEATS*DW-1:DW];
      job_tag <= fifo_head[JOB_W-1 -: TW];
    end else if (beat_accept) begin
      rest <= {{DW{1'b0}}, rest[REST_W-1:DW]};
    end
  end

  // sequencer FSM with registered handshake outputs and job cycle counting
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      beat_idx    <= '0;
      run_cnt     <= '0;
      wait_cnt    <= '0;
      cmd_valid   <= 1'b0;
      cmd_data    <= '0;
      resp_ready  <= 1'b0;
      done_valid  <= 1'b0;
      done_tag    <= '0;
      done_cycles <= '0;
      done_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state     <= ST_ISSUE;
            beat_idx  <= '0;
            cmd_valid <= 1'b1;
            cmd_data  <= fifo_head[DW-1:0];
          end
        end
        ST_ISSUE: begin
          // the job clock starts on beat 0 acceptance and runs every cycle after
          if (beat_idx != '0) run_cnt <= sat_inc(run_cnt);
          if (bus.cmd_ready_i) begin
            if (beat_idx == '0) run_cnt <= 32'd1;
            if (beat_idx == LAST_BEAT) begin
              state      <= ST_WAIT;
              cmd_valid  <= 1'b0;
              cmd_data   <= '0;
              resp_ready <= 1'b1;
              wait_cnt   <= '0;
            end else begin
              beat_idx <= beat_idx + 1'b1;
              cmd_data <= rest[DW-1:0];
            end
          end
        end
        ST_WAIT: begin
          run_cnt  <= sat_inc(run_cnt);
          wait_cnt <= wait_cnt + 32'd1;
          // a response on the final allowed cycle still counts as success
          if (bus.resp_valid_i || (wait_cnt == WAIT_LAST)) begin
            state       <= ST_DONE;
            resp_ready  <= 1'b0;
            done_valid  <= 1'b1;
            done_tag    <= job_tag;
            done_cycles <= sat_inc(run_cnt);
            done_err    <= !bus.resp_valid_i;
          end
        end
        ST_DONE: begin
          if (bus.done_ready_i) begin
            state      <= ST_IDLE;
            done_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_asic_cmd_seq.sv
// Bench for asic_cmd_seq: dut_a (default timeout) is checked every cycle
// against a job-level model plus directed literal expectations; dut_b
// (TIMEOUT = 8) is checked with directed literal expectations only.
module tb_asic_cmd_seq;

  localparam int TIMEOUT_A = 65535;
  localparam int P_IDLE = 0, P_ISSUE = 1, P_WAIT = 2, P_DONE = 3;

  logic clk = 1'b0;
  logic reset;

  asic_cmd_seq_if #(.DW(64), .TW(4)) ia ();
  asic_cmd_seq_if #(.DW(64), .TW(4)) ib ();

  asic_cmd_seq #(.DW(64), .TW(4), .TIMEOUT(TIMEOUT_A)) dut_a (
    .clk(clk), .reset(reset), .bus(ia));
  asic_cmd_seq #(.DW(64), .TW(4), .TIMEOUT(8)) dut_b (
    .clk(clk), .reset(reset), .bus(ib));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- job-level model of dut_a ----------------
  typedef struct packed {
    logic [3:0]       tag;
    logic [4:0][63:0] f;
  } job_t;

  job_t        mq[$];
  job_t        cur;
  int          ph = P_IDLE;
  int          beat = 0;
  int          t0 = 0;
  int          wcnt = 0;
  int          mcyc = 0;
  logic [3:0]  e_tag = '0;
  logic [31:0] e_cyc = '0;
  logic        e_err = 1'b0;
  bit          model_on = 1'b0;

  always @(negedge clk) begin
    bit   enq;
    job_t nj;
    mcyc++;
    if (model_on) begin
      chk("m_job_ready",  ia.job_ready_o,  64'(mq.size() < 2));
      chk("m_cmd_valid",  ia.cmd_valid_o,  64'(ph == P_ISSUE));
      if (ph == P_ISSUE) chk("m_cmd_data", ia.cmd_data_o, cur.f[beat]);
      chk("m_resp_ready", ia.resp_ready_o, 64'(ph == P_WAIT));
      chk("m_done_valid", ia.done_valid_o, 64'(ph == P_DONE));
      if (ph == P_DONE) begin
        chk("m_done_tag",    ia.done_tag_o,    64'(e_tag));
        chk("m_done_cycles", ia.done_cycles_o, 64'(e_cyc));
        chk("m_done_err",    ia.done_err_o,    64'(e_err));
      end
    end
    if (reset) begin
      mq.delete();
      ph = P_IDLE;
    end else begin
      enq = ia.job_valid_i && (mq.size() < 2);
      nj.tag = ia.job_tag_i;
      nj.f   = {ia.job_f4_i, ia.job_f3_i, ia.job_f2_i, ia.job_f1_i, ia.job_f0_i};
      case (ph)
        P_IDLE: if (mq.size() > 0) begin
          cur  = mq.pop_front();
          beat = 0;
          ph   = P_ISSUE;
        end
        P_ISSUE: if (ia.cmd_ready_i) begin
          if (beat == 0) t0 = mcyc;
          if (beat == 4) begin
            ph = P_WAIT;
            wcnt = 0;
          end else beat++;
        end
        P_WAIT: begin
          wcnt++;
          if (ia.resp_valid_i || wcnt == TIMEOUT_A) begin
            e_err = !ia.resp_valid_i;
            e_cyc = 32'(mcyc - t0 + 1);
            e_tag = cur.tag;
            ph    = P_DONE;
          end
        end
        default: if (ia.done_ready_i) ph = P_IDLE;
      endcase
      if (enq) mq.push_back(nj);
    end
  end

  // ---------------- stimulus helpers for dut_a ----------------
  task automatic push_a(input logic [63:0] f0, f1, f2, f3, f4, input logic [3:0] tag);
    int n;
    ia.job_f0_i = f0; ia.job_f1_i = f1; ia.job_f2_i = f2;
    ia.job_f3_i = f3; ia.job_f4_i = f4; ia.job_tag_i = tag;
    ia.job_valid_i = 1'b1;
    n = 0;
    while (!ia.job_ready_o && n < 200) begin tick(1); n++; end
    if (n >= 200) chk("push_a_timeout", 64'(n), 64'(0));
    tick(1);
    ia.job_valid_i = 1'b0;
  endtask

  task automatic wait_resp_ready_a();
    int n = 0;
    while (!ia.resp_ready_o && n < 100) begin tick(1); n++; end
    chk("wait_resp_ready_a", ia.resp_ready_o, 1);
  endtask

  task automatic wait_done_a();
    int n = 0;
    while (!ia.done_valid_o && n < 100) begin tick(1); n++; end
    chk("wait_done_valid_a", ia.done_valid_o, 1);
  endtask

  task automatic wait_cmd_valid_a();
    int n = 0;
    while (!ia.cmd_valid_o && n < 100) begin tick(1); n++; end
    chk("wait_cmd_valid_a", ia.cmd_valid_o, 1);
  endtask

  task automatic resp_pulse_a();
    ia.resp_valid_i = 1'b1;
    tick(1);
    ia.resp_valid_i = 1'b0;
  endtask

  logic [63:0] exp_beats [5] = '{64'h10, 64'h20, 64'h30, 64'h04, 64'h04};
  logic [3:0]  tags3 [3]     = '{4'd7, 4'd8, 4'd9};

  initial begin
    int n;
    reset = 1'b1;
    ia.job_valid_i = 0; ia.job_f0_i = 0; ia.job_f1_i = 0; ia.job_f2_i = 0;
    ia.job_f3_i = 0; ia.job_f4_i = 0; ia.job_tag_i = 0;
    ia.cmd_ready_i = 1; ia.resp_valid_i = 0; ia.done_ready_i = 1;
    ib.job_valid_i = 0; ib.job_f0_i = 0; ib.job_f1_i = 0; ib.job_f2_i = 0;
    ib.job_f3_i = 0; ib.job_f4_i = 0; ib.job_tag_i = 0;
    ib.cmd_ready_i = 1; ib.resp_valid_i = 0; ib.done_ready_i = 0;
    tick(2);
    reset = 1'b0;

    // reset state
    chk("rst_job_ready",   ia.job_ready_o,   1);
    chk("rst_cmd_valid",   ia.cmd_valid_o,   0);
    chk("rst_cmd_data",    ia.cmd_data_o,    0);
    chk("rst_resp_ready",  ia.resp_ready_o,  0);
    chk("rst_done_valid",  ia.done_valid_o,  0);
    chk("rst_done_tag",    ia.done_tag_o,    0);
    chk("rst_done_cycles", ia.done_cycles_o, 0);
    chk("rst_done_err",    ia.done_err_o,    0);
    model_on = 1'b1;

    // single job, 5 consecutive beats, resp on the 20th WAIT cycle
    ia.done_ready_i = 0;
    push_a(64'h10, 64'h20, 64'h30, 64'h04, 64'h04, 4'd3);
    wait_cmd_valid_a();
    for (int k = 0; k < 5; k++) begin
      chk("t1_beat_valid", ia.cmd_valid_o, 1);
      chk("t1_beat_data",  ia.cmd_data_o,  exp_beats[k]);
      tick(1);
    end
    chk("t1_after_beats_valid", ia.cmd_valid_o, 0);
    chk("t1_wait_resp_ready",   ia.resp_ready_o, 1);
    tick(19);
    resp_pulse_a();
    chk("t1_done_valid",  ia.done_valid_o,  1);
    chk("t1_done_tag",    ia.done_tag_o,    3);
    chk("t1_done_cycles", ia.done_cycles_o, 25);
    chk("t1_done_err",    ia.done_err_o,    0);
    ia.done_ready_i = 1;
    tick(2);

    // backpressure on beat 2
    push_a(64'h10, 64'h20, 64'h30, 64'h04, 64'h04, 4'd5);
    wait_cmd_valid_a();
    tick(2);
    ia.cmd_ready_i = 0;
    for (int k = 0; k < 3; k++) begin
      chk("t2_stall_data",  ia.cmd_data_o,  64'h30);
      chk("t2_stall_valid", ia.cmd_valid_o, 1);
      tick(1);
    end
    ia.cmd_ready_i = 1;
    chk("t2_release_data", ia.cmd_data_o, 64'h30);
    tick(1);
    chk("t2_beat3", ia.cmd_data_o, 64'h04);
    tick(1);
    chk("t2_beat4", ia.cmd_data_o, 64'h04);
    tick(1);
    chk("t2_no_extra_beat", ia.cmd_valid_o, 0);
    resp_pulse_a();
    tick(2);

    // three jobs back-to-back, FIFO fills while job A is stalled
    ia.cmd_ready_i = 0;
    push_a(64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'hA4, tags3[0]);
    push_a(64'hB0, 64'hB1, 64'hB2, 64'hB3, 64'hB4, tags3[1]);
    push_a(64'hC0, 64'hC1, 64'hC2, 64'hC3, 64'hC4, tags3[2]);
    chk("t3_full_ready", ia.job_ready_o, 0);
    ia.job_f0_i = 64'hD0; ia.job_tag_i = 4'hD; ia.job_valid_i = 1;
    for (int k = 0; k < 3; k++) begin
      chk("t3_full_hold", ia.job_ready_o, 0);
      tick(1);
    end
    ia.job_valid_i = 0;
    ia.cmd_ready_i = 1;
    for (int j = 0; j < 3; j++) begin
      wait_resp_ready_a();
      tick(j);
      resp_pulse_a();
      wait_done_a();
      chk("t3_done_tag", ia.done_tag_o, 64'(tags3[j]));
      tick(1);
    end
    tick(3);

    // completion record held while host stalls; next job waits for it
    ia.done_ready_i = 0;
    push_a(64'h1, 64'h2, 64'h3, 64'h4, 64'h5, 4'hA);
    push_a(64'h6, 64'h7, 64'h8, 64'h9, 64'hB, 4'hB);
    wait_resp_ready_a();
    resp_pulse_a();
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_valid",  ia.done_valid_o,  1);
      chk("t4_hold_tag",    ia.done_tag_o,    4'hA);
      chk("t4_hold_cycles", ia.done_cycles_o, 6);
      chk("t4_no_issue",    ia.cmd_valid_o,   0);
      tick(1);
    end
    ia.done_ready_i = 1;
    tick(1);
    chk("t4_released",     ia.done_valid_o, 0);
    chk("t4_idle_no_cmd",  ia.cmd_valid_o,  0);
    tick(1);
    chk("t4_next_valid",   ia.cmd_valid_o,  1);
    chk("t4_next_data",    ia.cmd_data_o,   64'h6);
    wait_resp_ready_a();
    resp_pulse_a();
    chk("t4_next_tag",     ia.done_tag_o,   4'hB);
    tick(2);

    // reset while waiting with a second job queued
    push_a(64'h11, 64'h12, 64'h13, 64'h14, 64'h15, 4'h1);
    push_a(64'h21, 64'h22, 64'h23, 64'h24, 64'h25, 4'h2);
    wait_resp_ready_a();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t5_job_ready",   ia.job_ready_o,   1);
    chk("t5_cmd_valid",   ia.cmd_valid_o,   0);
    chk("t5_cmd_data",    ia.cmd_data_o,    0);
    chk("t5_resp_ready",  ia.resp_ready_o,  0);
    chk("t5_done_valid",  ia.done_valid_o,  0);
    chk("t5_done_tag",    ia.done_tag_o,    0);
    chk("t5_done_cycles", ia.done_cycles_o, 0);
    chk("t5_done_err",    ia.done_err_o,    0);
    tick(4);
    chk("t5_stays_idle",  ia.cmd_valid_o,   0);
    chk("t5_no_record",   ia.done_valid_o,  0);

    // dut_b: timeout after 8 WAIT cycles, then resp on the 8th cycle
    ib.job_f0_i = 64'h55; ib.job_tag_i = 4'h6; ib.job_valid_i = 1;
    tick(1);
    ib.job_valid_i = 0;
    n = 0;
    while (!ib.resp_ready_o && n < 100) begin tick(1); n++; end
    chk("tb_wait_resp_ready", ib.resp_ready_o, 1);
    tick(6);
    chk("tb_cycle7_not_done", ib.done_valid_o, 0);
    tick(1);
    chk("tb_cycle8_not_done", ib.done_valid_o, 0);
    chk("tb_cycle8_waiting",  ib.resp_ready_o, 1);
    tick(1);
    chk("tb_to_valid",  ib.done_valid_o,  1);
    chk("tb_to_err",    ib.done_err_o,    1);
    chk("tb_to_tag",    ib.done_tag_o,    4'h6);
    chk("tb_to_cycles", ib.done_cycles_o, 13);
    chk("tb_to_no_ack", ib.resp_ready_o,  0);
    ib.done_ready_i = 1;
    tick(2);
    ib.job_tag_i = 4'h9; ib.job_valid_i = 1;
    tick(1);
    ib.job_valid_i = 0;
    n = 0;
    while (!ib.resp_ready_o && n < 100) begin tick(1); n++; end
    chk("tb2_wait_resp_ready", ib.resp_ready_o, 1);
    tick(7);
    ib.resp_valid_i = 1;
    tick(1);
    ib.resp_valid_i = 0;
    chk("tb2_valid",  ib.done_valid_o,  1);
    chk("tb2_err",    ib.done_err_o,    0);
    chk("tb2_tag",    ib.done_tag_o,    4'h9);
    chk("tb2_cycles", ib.done_cycles_o, 13);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation time limit, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/asic_cmd_seq.md
ASIC_CMD_SEQ -- requirements
Module: asic_cmd_seq

Interface
REQ-001 Parameter DW, 64: width of one command beat and of each job field.
REQ-002 Parameter TW, 4: job tag width.
REQ-003 Parameter TIMEOUT, 65535: maximum cycles allowed in WAIT before the job is aborted with error.
REQ-004 clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-005 job_valid_i  in  1  host job descriptor valid.
REQ-006 job_ready_o  out  1  job FIFO can accept a descriptor.
REQ-007 job_f0_i..job_f4_i  in  DW each  descriptor fields 0..4 (W base, X base, R base, row count, col count).
REQ-008 job_tag_i  in  TW  host tag.
REQ-009 cmd_valid_o  out  1  command beat valid toward the ASIC controller.
REQ-010 cmd_ready_i  in  1  ASIC controller accepts the beat.
REQ-011 cmd_data_o  out  DW  command beat payload.
REQ-012 resp_valid_i  in  1  ASIC controller reports job complete.
REQ-013 resp_ready_o  out  1  sequencer accepts completion.
REQ-014 done_valid_o  out  1  completion record valid toward host.
REQ-015 done_ready_i  in  1  host accepts completion record.
REQ-016 done_tag_o  out  TW  tag of the completed job.
REQ-017 done_cycles_o  out  32  cycles from first beat accepted to resp accepted.
REQ-018 done_err_o  out  1  1 = job aborted by timeout.

Function
REQ-019 Descriptors SHALL be buffered in a 2-entry FIFO; job_ready_o = FIFO not full; an enqueue occurs when job_valid_i && job_ready_o.
REQ-020 A simultaneous enqueue and dequeue when the FIFO is full SHALL NOT be accepted (job_ready_o reflects full only); when empty, an enqueue is visible to the FSM the next cycle (no fall-through).
REQ-021 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-022 IDLE -> ISSUE when FIFO non-empty; the head is popped and latched on that transition; beat index cleared to 0.
REQ-023 In ISSUE, cmd_valid_o = 1 and cmd_data_o = latched field[beat index]; the index increments on each cycle with cmd_valid_o && cmd_ready_i.
REQ-024 cmd_data_o SHALL hold stable while cmd_valid_o && !cmd_ready_i.
REQ-025 ISSUE -> WAIT on acceptance of beat 4; exactly 5 beats SHALL be issued per job, in order f0..f4.
REQ-026 The cycle counter SHALL clear to 1 on acceptance of beat 0, increment every cycle thereafter, saturate at 0xFFFF_FFFF, and stop when resp is accepted.
REQ-027 In WAIT, resp_ready_o = 1; resp_valid_i moves WAIT -> DONE with done_err_o = 0; resp_ready_o = 0 in all other states.
REQ-028 The WAIT-cycle count reaching TIMEOUT without resp_valid_i SHALL move WAIT -> DONE with done_err_o = 1; resp_valid_i on that same cycle takes priority (err = 0).
REQ-029 In DONE, done_valid_o = 1 with tag/cycles/err stable; DONE -> IDLE on done_ready_i.
REQ-030 resp_valid_i outside WAIT SHALL be ignored (not acknowledged).
REQ-031 Only one job SHALL be in flight; the FIFO keeps accepting descriptors during ISSUE/WAIT/DONE.

Reset
REQ-032 On reset: state IDLE, FIFO empty, job_ready_o = 1, cmd_valid_o = 0, cmd_data_o = 0, resp_ready_o = 0, done_valid_o = 0, done_tag_o = 0, done_cycles_o = 0, done_err_o = 0.
REQ-033 Reset mid-job SHALL discard the in-flight job and all queued descriptors with no done record produced.

Structure
REQ-034 State enum, beat count (5), and the DW/TW defaults SHALL live in the shared asic package used by the controller.
REQ-035 The 2-entry FIFO SHALL be a separate sub-module, asic_job_fifo, parameterised by payload width.

Verification
REQ-036 Single job, f0..f4 = 0x10,0x20,0x30,0x04,0x04, tag 3, cmd_ready_i tied 1, resp after 20 WAIT cycles -> 5 beats on 5 consecutive cycles in order; done tag 3, cycles 25, err 0.
REQ-037 Backpressure: cmd_ready_i low for 3 cycles on beat 2 -> cmd_data_o holds 0x30 stable; no beat is skipped or duplicated.
REQ-038 Three jobs back-to-back with FIFO full -> job_ready_o = 0 after two enqueues; all three complete in order with correct tags.
REQ-039 Timeout: TIMEOUT = 8, no resp -> done_err_o = 1 after 8 WAIT cycles; resp on cycle 8 -> err 0.
REQ-040 Reset asserted in WAIT with one job queued -> all outputs at reset values the next cycle; no done record; FIFO empty.
REQ-041 done_ready_i held low 5 cycles -> done record stable; next job does not start issuing until the record is accepted.
